// File: rtl/ifu_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ifu_fetch_ctrl_pkg
//  Purpose  : Shared state encoding, widths and helpers for the fetch stage.
//  Revision : 1.0 - initial release
// ============================================================================
package ifu_fetch_ctrl_pkg;

    localparam int          WORD_W       = 32;
    localparam int          IMM_W        = 16;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_ERR   = 2'd3
    } state_e;

    // Sign-extended branch immediate scaled to a byte offset.
    function automatic logic [WORD_W-1:0] branch_offset(input logic [IMM_W-1:0] imm);
        return {{(WORD_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : ifu_fetch_ctrl_if
//  Purpose  : Instruction-memory and decode-side signals of the fetch stage.
//  Revision : 1.0 - initial release
// ============================================================================
interface ifu_fetch_ctrl_if;
    import ifu_fetch_ctrl_pkg::*;

    logic              imem_req;
    logic [WORD_W-1:0] imem_addr;
    logic              imem_ack;
    logic [WORD_W-1:0] imem_rdata;
    logic              instr_valid;
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_plus4;
    logic              stall;
    logic              branch_taken;
    logic [IMM_W-1:0]  branch_imm;
    logic              jump;
    logic [25:0]       jump_target;
    logic              jump_reg;
    logic [WORD_W-1:0] jr_target;
    logic              fetch_err;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, pc, pc_plus4, fetch_err,
        input  imem_ack, imem_rdata, stall, branch_taken, branch_imm,
               jump, jump_target, jump_reg, jr_target
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, pc, pc_plus4, fetch_err,
        output imem_ack, imem_rdata, stall, branch_taken, branch_imm,
               jump, jump_target, jump_reg, jr_target
    );

endinterface
`default_nettype wire

// File: rtl/ifu_fetch_ctrl_next_pc_sel.sv
`default_nettype none
// ============================================================================
//  Module   : ifu_fetch_ctrl_next_pc_sel
//  Purpose  : Combinational next-PC priority mux (jr > j > branch > seq).
//  Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch_ctrl_next_pc_sel
    import ifu_fetch_ctrl_pkg::*;
(
    input  wire logic [WORD_W-1:0] pc_plus4_i,
    input  wire logic              branch_taken_i,
    input  wire logic [IMM_W-1:0]  branch_imm_i,
    input  wire logic              jump_i,
    input  wire logic [25:0]       jump_target_i,
    input  wire logic              jump_reg_i,
    input  wire logic [WORD_W-1:0] jr_target_i,
    output logic      [WORD_W-1:0] next_pc_o
);

    always_comb begin
        next_pc_o = pc_plus4_i;
        if (jump_reg_i) begin
            next_pc_o = jr_target_i;
        end else if (jump_i) begin
            next_pc_o = {pc_plus4_i[31:28], jump_target_i, 2'b00};
        end else if (branch_taken_i) begin
            next_pc_o = pc_plus4_i + branch_offset(branch_imm_i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifu_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ifu_fetch_ctrl
//  Purpose  : PC ownership, imem req/ack fetch and single-entry issue to decode.
//             Optional macro IFU_MISALIGN_CHECK_EN traps misaligned JR targets.
//  Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch_ctrl
    import ifu_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
    parameter int unsigned ACK_TIMEOUT = 0
) (
    input  wire logic           clk,
    input  wire logic           reset,
    ifu_fetch_ctrl_if.master    bus
);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] w_pc_plus4;
    logic [WORD_W-1:0] w_jr_target;
    logic [WORD_W-1:0] w_next_pc;
    logic              w_timeout;

    assign w_pc_plus4 = pc_q + 32'd4;

`ifdef IFU_MISALIGN_CHECK_EN
    assign w_jr_target = bus.jr_target;
`else
    assign w_jr_target = bus.jr_target & ~32'h0000_0003;
`endif

    ifu_fetch_ctrl_next_pc_sel u_next_pc_sel (
        .pc_plus4_i     (w_pc_plus4),
        .branch_taken_i (bus.branch_taken),
        .branch_imm_i   (bus.branch_imm),
        .jump_i         (bus.jump),
        .jump_target_i  (bus.jump_target),
        .jump_reg_i     (bus.jump_reg),
        .jr_target_i    (w_jr_target),
        .next_pc_o      (w_next_pc)
    );

    generate
        if (ACK_TIMEOUT > 0) begin : g_timeout
            localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
            logic [CNT_W-1:0] cnt_q;

            // Held at zero outside S_FETCH so every fetch starts a fresh count.
            always_ff @(posedge clk) begin
                if (reset || (state_q != S_FETCH)) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign w_timeout = (state_q == S_FETCH) && (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RESET;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                // Ack wins over a timeout landing in the same cycle.
                if (bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    state_d = S_ISSUE;
                end else if (w_timeout) begin
                    state_d = S_ERR;
                end
            end
            S_ISSUE: begin
                if (!bus.stall) begin
                    pc_d    = w_next_pc;
`ifdef IFU_MISALIGN_CHECK_EN
                    state_d = (w_next_pc[1:0] != 2'b00) ? S_ERR : S_FETCH;
`else
                    state_d = S_FETCH;
`endif
                end
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_RESET;
        endcase
    end

    assign bus.imem_req    = (state_q == S_FETCH);
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = (state_q == S_ISSUE);
    assign bus.instr       = instr_q;
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = w_pc_plus4;
    assign bus.fetch_err   = (state_q == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ifu_fetch_ctrl
//  Purpose  : Directed self-checking bench for ifu_fetch_ctrl (ACK_TIMEOUT=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic ack_en;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    ifu_fetch_ctrl_if bus ();

    ifu_fetch_ctrl #(
        .RESET_PC    (32'h0000_0000),
        .ACK_TIMEOUT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2010_0004;
            32'h0000_0004: return 32'h2011_000C;
            default:       return 32'hC0DE_0000 ^ a;
        endcase
    endfunction

    // Zero-latency memory: ack in the same cycle as req when enabled.
    assign bus.imem_ack   = ack_en & bus.imem_req;
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_redirect();
        bus.branch_taken = 1'b0;
        bus.branch_imm   = '0;
        bus.jump         = 1'b0;
        bus.jump_target  = '0;
        bus.jump_reg     = 1'b0;
        bus.jr_target    = '0;
    endtask

    initial begin
        reset     = 1'b1;
        ack_en    = 1'b1;
        bus.stall = 1'b0;
        clear_redirect();
        tick();
        tick();
        chk("rst_req",   32'(bus.imem_req),    32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_pc",    bus.pc,               32'h0);
        chk("rst_instr", bus.instr,            32'h0);
        chk("rst_err",   32'(bus.fetch_err),   32'd0);

        // Sequential fetch of two words, 2 cycles each.
        reset = 1'b0;
        tick();
        chk("f0_req",   32'(bus.imem_req),    32'd1);
        chk("f0_addr",  bus.imem_addr,        32'h0);
        chk("f0_valid", 32'(bus.instr_valid), 32'd0);
        tick();
        chk("i0_valid", 32'(bus.instr_valid), 32'd1);
        chk("i0_instr", bus.instr,            32'h2010_0004);
        chk("i0_pc",    bus.pc,               32'h0);
        chk("i0_pc4",   bus.pc_plus4,         32'h4);
        tick();
        chk("f1_addr",  bus.imem_addr,        32'h4);
        tick();
        chk("i1_valid", 32'(bus.instr_valid), 32'd1);
        chk("i1_instr", bus.instr,            32'h2011_000C);
        chk("i1_pc",    bus.pc,               32'h4);
        chk("i1_pc4",   bus.pc_plus4,         32'h8);
        tick();
        tick();
        chk("i2_pc",    bus.pc,               32'h8);

        // Backward branch: 0xC + (-2 << 2) = 0x4.
        bus.branch_taken = 1'b1;
        bus.branch_imm   = 16'hFFFE;
        tick();
        chk("br_neg_addr", bus.imem_addr, 32'h4);
        clear_redirect();
        tick();
        tick();
        tick();
        chk("i3_pc", bus.pc, 32'h8);

        // Forward branch: 0xC + (3 << 2) = 0x18.
        bus.branch_taken = 1'b1;
        bus.branch_imm   = 16'h0003;
        tick();
        chk("br_pos_addr", bus.imem_addr, 32'h18);
        clear_redirect();
        tick();

        // All redirects together: jump_reg wins.
        bus.jump_reg     = 1'b1;
        bus.jr_target    = 32'h40;
        bus.jump         = 1'b1;
        bus.jump_target  = 26'h3FF;
        bus.branch_taken = 1'b1;
        bus.branch_imm   = 16'h0100;
        tick();
        chk("prio_addr", bus.imem_addr, 32'h40);
        clear_redirect();
        tick();

        bus.jump_reg  = 1'b1;
        bus.jr_target = 32'h1000_0000;
        tick();
        clear_redirect();
        tick();
        chk("jr_pc", bus.pc, 32'h1000_0000);
        bus.jump        = 1'b1;
        bus.jump_target = 26'h10;
        tick();
        chk("j_addr", bus.imem_addr, 32'h1000_0040);
        clear_redirect();
        tick();

        // Stall with redirect inputs toggling: everything holds.
        bus.stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.branch_taken = i[0];
            bus.jump         = i[1];
            bus.jump_reg     = ~i[0];
            bus.jr_target    = 32'h0000_1000 + 32'(i * 16);
            bus.branch_imm   = 16'(i + 1);
            tick();
            chk("stall_valid", 32'(bus.instr_valid), 32'd1);
            chk("stall_pc",    bus.pc,               32'h1000_0040);
            chk("stall_instr", bus.instr,            mem_word(32'h1000_0040));
            chk("stall_req",   32'(bus.imem_req),    32'd0);
        end
        clear_redirect();
        bus.stall = 1'b0;
        tick();
        chk("unstall_addr", bus.imem_addr, 32'h1000_0044);
        tick();

        // PC wrap at the top of the address space.
        bus.jump_reg  = 1'b1;
        bus.jr_target = 32'hFFFF_FFFC;
        tick();
        clear_redirect();
        tick();
        chk("wrap_pc4", bus.pc_plus4, 32'h0);
        tick();
        chk("wrap_addr", bus.imem_addr, 32'h0);
        tick();

        // Misaligned JR target.
        bus.jump_reg  = 1'b1;
        bus.jr_target = 32'h22;
        tick();
        clear_redirect();
`ifdef IFU_MISALIGN_CHECK_EN
        chk("mis_err",   32'(bus.fetch_err), 32'd1);
        chk("mis_pc",    bus.pc,             32'h22);
        chk("mis_req",   32'(bus.imem_req),  32'd0);
        tick();
        chk("mis_sticky", 32'(bus.fetch_err), 32'd1);
`else
        chk("mis_err",   32'(bus.fetch_err), 32'd0);
        chk("mis_addr",  bus.imem_addr,      32'h20);
        chk("mis_req",   32'(bus.imem_req),  32'd1);
`endif

        // Ack timeout: four req cycles then sticky error.
        reset  = 1'b1;
        ack_en = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("to_req4", 32'(bus.imem_req),  32'd1);
        chk("to_err4", 32'(bus.fetch_err), 32'd0);
        tick();
        chk("to_err",   32'(bus.fetch_err),   32'd1);
        chk("to_req",   32'(bus.imem_req),    32'd0);
        chk("to_valid", 32'(bus.instr_valid), 32'd0);
        ack_en = 1'b1;
        tick();
        chk("to_sticky", 32'(bus.fetch_err), 32'd1);

        // Ack on the last allowed cycle is a success.
        reset  = 1'b1;
        ack_en = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        tick();
        ack_en = 1'b1;
        tick();
        chk("late_valid", 32'(bus.instr_valid), 32'd1);
        chk("late_err",   32'(bus.fetch_err),   32'd0);
        chk("late_instr", bus.instr,            32'h2010_0004);

        // Reset during S_FETCH with a concurrent ack drops the ack.
        tick();
        chk("mid_req", 32'(bus.imem_req), 32'd1);
        reset = 1'b1;
        tick();
        chk("mid_instr", bus.instr,            32'h0);
        chk("mid_pc",    bus.pc,               32'h0);
        chk("mid_valid", 32'(bus.instr_valid), 32'd0);
        chk("mid_req0",  32'(bus.imem_req),    32'd0);
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
- Instruction-fetch control stage sitting directly upstream of decode/register-read in the MIPS core.
- Owns the PC register and next-PC selection (sequential, branch, jump, jump-register).
- Runs a req/ack handshake to instruction memory and presents one instruction at a time to decode with a valid/stall handshake.
- Branch/jump resolution comes back from downstream for the instruction currently presented.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
ACK_TIMEOUT, 0, max cycles from imem_req rise to imem_ack before error; 0 disables the check

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch byte address; equals pc
imem_ack  in  1  rdata valid this cycle
imem_rdata  in  32  fetched instruction word
instr_valid  out  1  instr/pc/pc_plus4 valid for decode
instr  out  32  latched instruction
pc  out  32  address of instr
pc_plus4  out  32  pc + 4, used for link writes
stall  in  1  decode not consuming this cycle
branch_taken  in  1  conditional branch resolved taken
branch_imm  in  16  raw branch immediate
jump  in  1  J/JAL
jump_target  in  26  instr_index field
jump_reg  in  1  JR/JALR
jr_target  in  32  register target
fetch_err  out  1  sticky fetch error

Behaviour:
- Reset (clk edge with reset=1): state S_RESET; pc=RESET_PC; instr=0; instr_valid=0; imem_req=0; fetch_err=0. Reset has priority over everything, including an ack in the same cycle, which is dropped.
- States:
  - S_RESET: unconditional transition to S_FETCH next cycle.
  - S_FETCH: imem_req=1, imem_addr=pc, both stable until ack. On imem_ack: instr<=imem_rdata, go to S_ISSUE. Ack in the same cycle as req is legal (combinational memory).
  - S_ISSUE: instr_valid=1; instr, pc and pc_plus4 are stable. If stall=1, hold; redirect inputs are ignored. If stall=0, the instruction is consumed: pc<=next_pc, go to S_FETCH.
  - S_ERR: imem_req=0, instr_valid=0, fetch_err=1. Left only by reset.
- imem_ack outside S_FETCH is ignored.
- Throughput: 2 cycles/instruction with zero-latency memory and no stall.
- next_pc, evaluated only on the consume cycle; priority jump_reg > jump > branch_taken > sequential:
  - jump_reg: jr_target.
  - jump: {pc_plus4[31:28], jump_target, 2'b00}.
  - branch_taken: pc_plus4 + (sign_extend(branch_imm) << 2), mod 2^32.
  - else: pc_plus4.
- Arithmetic: all PC arithmetic is 32-bit and wraps (pc 32'hFFFF_FFFC sequential -> 0). No delay slot: the redirect applies to the instruction after the one presented.
- Timeout: when ACK_TIMEOUT>0, a counter runs in S_FETCH and clears on entry to S_FETCH. Reaching ACK_TIMEOUT without ack -> S_ERR. An ack on the exact cycle the count reaches ACK_TIMEOUT counts as success.
- Outputs are driven from registers or state only; there is no combinational path from stall or redirect inputs to any output.

Optional Feature:
IFU_MISALIGN_CHECK_EN
- Defined: on a consume cycle where next_pc[1:0]!=0 (only possible via jump_reg), pc is still loaded with the misaligned value, no request is issued, and the state goes to S_ERR with fetch_err=1. The bad address stays visible on pc.
- Undefined: jr_target[1:0] is forced to 2'b00 and fetch proceeds normally; fetch_err comes only from timeout.

Decomposition:
- Shared package: state encoding (S_RESET, S_FETCH, S_ISSUE, S_ERR), width constants WORD_W=32 and IMM_W=16, RESET_PC default.
- Sub-module next_pc_sel: purely combinational next-PC priority mux and adders. The FSM, counter and registers stay in ifu_fetch_ctrl.

Test Plan:
- Reset, then memory with ack=req returning 32'h2010_0004 at 0, 32'h2011_000C at 4 -> instr_valid on cycles 2 and 4 after reset release, pc 0 then 4, pc_plus4 4 then 8.
- pc=8, branch_taken=1, branch_imm=16'hFFFE on consume -> next imem_addr=32'h0000_0004. Same with branch_imm=3 -> 32'h0000_0018.
- jump=1, jump_reg=1, branch_taken=1 together, jr_target=32'h40 -> next fetch at 32'h40. jump only with target 26'h10 at pc=32'h1000_0000 -> 32'h1000_0040.
- stall=1 for 5 cycles with redirect inputs toggling -> instr, pc and instr_valid unchanged, no imem_req. Release with no redirect -> sequential fetch.
- ACK_TIMEOUT=4, ack never arrives -> fetch_err=1 in S_ERR after 4 req cycles. Reset mid-S_FETCH with ack in the same cycle -> instr stays 0, pc=RESET_PC.
- With IFU_MISALIGN_CHECK_EN, jump_reg to 32'h22 -> fetch_err=1, pc=32'h22, no req. Without the macro -> fetch at 32'h20.
